// File: rtl/pulse_rate_monitor.sv
// Pulse-rate monitor: classifies current/voltage samples, counts per-class hits per window,
// and reports class percentages via a sequential divider. Optional macro: PULSE_RATE_INTERVAL_EN.
module pulse_rate_monitor #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sample_valid,
    input  logic signed [DATA_W-1:0] sample_current,
    input  logic signed [DATA_W-1:0] sample_voltage,
    input  logic signed [DATA_W-1:0] thr_v_open,
    input  logic signed [DATA_W-1:0] thr_v_short,
    input  logic signed [DATA_W-1:0] thr_i_dis,
    input  logic [15:0]              thr_delay,
    input  logic                     window_end,
    output logic                     busy,
    output logic                     rate_valid,
    output logic [7:0]               normal_rate,
    output logic [7:0]               arc_rate,
    output logic [7:0]               open_rate,
    output logic [7:0]               short_rate
);
    localparam int Q = CNT_W + 7;
    localparam logic [5:0] Q_LAST = 6'(Q - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {C_INTERVAL, C_NORMAL, C_ARC, C_OPEN, C_SHORT} cls_e;
    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_e;

    function automatic logic [Q-1:0] mul100(input logic [CNT_W-1:0] c);
        logic [Q-1:0] e;
        e = {7'b0, c};
        return (e << 6) + (e << 5) + (e << 2);
    endfunction

    cls_e               cls_s, cls_r, prev_cls_r;
    logic               cls_vld_r;
    logic [15:0]        open_run_r;
    logic               v_open_s, v_short_s, i_dis_s;
    // Counter slots: 0 normal, 1 arc, 2 open, 3 short, 4 interval, 5 total
    logic [CNT_W-1:0]   cnt_r [6];
    logic [5:0]         inc_s;
    logic               sat_s, ovf_r, win_clr_s;
    logic [CNT_W-1:0]   sh_r [4];
    logic [CNT_W-1:0]   sh_total_r;
    logic               sh_ovf_r;
    state_e             state_r, state_s;
    logic               ld_r;
    logic [1:0]         idx_r;
    logic [5:0]         step_r;
    logic [Q-1:0]       num_r, num_nx_s;
    logic [CNT_W-1:0]   rem_r, rem_nx_s;
    logic [CNT_W:0]     rem_sh_s, diff_s;
    logic               ge_s, div_skip_s;
    logic [7:0]         q_r [4];

    assign v_open_s  = (sample_voltage >= thr_v_open);
    assign v_short_s = (sample_voltage > thr_v_short);
    assign i_dis_s   = (sample_current > thr_i_dis);
    assign win_clr_s = (state_r == S_IDLE) && window_end;

    // Sample classification
    always_comb begin
        cls_s = C_INTERVAL;
        if (v_open_s) begin
            cls_s = C_OPEN;
        end else if (v_short_s && i_dis_s) begin
            if ((open_run_r >= thr_delay) || (prev_cls_r == C_NORMAL)) cls_s = C_NORMAL;
            else cls_s = C_ARC;
        end else if (v_short_s) begin
            cls_s = C_OPEN;
        end else if (i_dis_s) begin
            cls_s = C_SHORT;
        end else begin
            cls_s = C_INTERVAL;
        end
    end

    // Classification pipeline register, open-run tracker and previous-class history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cls_r      <= C_INTERVAL;
            prev_cls_r <= C_INTERVAL;
            cls_vld_r  <= 1'b0;
            open_run_r <= 16'd0;
        end else begin
            cls_vld_r <= sample_valid;
            if (sample_valid) begin
                cls_r      <= cls_s;
                prev_cls_r <= cls_s;
                if (cls_s != C_OPEN) open_run_r <= 16'd0;
                else if (open_run_r != 16'hFFFF) open_run_r <= open_run_r + 16'd1;
            end
        end
    end

    // Counter increment vector and saturation detect
    always_comb begin
        inc_s = 6'b000000;
        if (cls_vld_r) begin
            case (cls_r)
                C_NORMAL:   inc_s = 6'b100001;
                C_ARC:      inc_s = 6'b100010;
                C_OPEN:     inc_s = 6'b100100;
                C_SHORT:    inc_s = 6'b101000;
`ifdef PULSE_RATE_INTERVAL_EN
                C_INTERVAL: inc_s = 6'b110000;
`else
                C_INTERVAL: inc_s = 6'b000000;
`endif
                default:    inc_s = 6'b000000;
            endcase
        end else begin
            inc_s = 6'b000000;
        end
        sat_s = 1'b0;
        for (int k = 0; k < 6; k++) sat_s = sat_s | (inc_s[k] & (cnt_r[k] == CNT_MAX));
    end

    // Live counters, sticky overflow and window snapshot; a sample landing on window close opens the new window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 6; k++) cnt_r[k] <= '0;
            for (int k = 0; k < 4; k++) sh_r[k] <= '0;
            sh_total_r <= '0;
            sh_ovf_r   <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            for (int k = 0; k < 6; k++) begin
                if (win_clr_s) cnt_r[k] <= {{(CNT_W-1){1'b0}}, inc_s[k]};
                else if (inc_s[k] && (cnt_r[k] != CNT_MAX)) cnt_r[k] <= cnt_r[k] + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (win_clr_s) begin
                for (int k = 0; k < 4; k++) sh_r[k] <= cnt_r[k];
                sh_total_r <= cnt_r[5];
                sh_ovf_r   <= ovf_r | sat_s;
                ovf_r      <= 1'b0;
            end else if (sat_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    // Restoring divider step
    assign rem_sh_s   = {rem_r, num_r[Q-1]};
    assign diff_s     = rem_sh_s - {1'b0, sh_total_r};
    assign ge_s       = ~diff_s[CNT_W];
    assign rem_nx_s   = ge_s ? diff_s[CNT_W-1:0] : rem_sh_s[CNT_W-1:0];
    assign num_nx_s   = {num_r[Q-2:0], ge_s};
    assign div_skip_s = sh_ovf_r || (sh_total_r == '0);

    // FSM next state
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: if (window_end) state_s = S_DIV; else state_s = S_IDLE;
            S_DIV:  if (!ld_r && (step_r == Q_LAST) && (idx_r == 2'd3)) state_s = S_DONE;
                    else state_s = S_DIV;
            S_DONE: state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= S_IDLE;
        else state_r <= state_s;
    end

    // Divider datapath; first DIV cycle loads from the freshly captured shadows
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_r   <= 1'b1;
            idx_r  <= 2'd0;
            step_r <= 6'd0;
            num_r  <= '0;
            rem_r  <= '0;
            for (int k = 0; k < 4; k++) q_r[k] <= 8'd0;
        end else begin
            case (state_r)
                S_DIV: begin
                    if (ld_r) begin
                        ld_r   <= 1'b0;
                        num_r  <= mul100(sh_r[0]);
                        rem_r  <= '0;
                        step_r <= 6'd0;
                        idx_r  <= 2'd0;
                    end else if (step_r == Q_LAST) begin
                        q_r[idx_r] <= num_nx_s[7:0];
                        idx_r      <= idx_r + 2'd1;
                        step_r     <= 6'd0;
                        rem_r      <= '0;
                        num_r      <= mul100(sh_r[idx_r + 2'd1]);
                    end else begin
                        step_r <= step_r + 6'd1;
                        if (!div_skip_s) begin
                            num_r <= num_nx_s;
                            rem_r <= rem_nx_s;
                        end
                    end
                end
                default: begin
                    ld_r   <= 1'b1;
                    idx_r  <= 2'd0;
                    step_r <= 6'd0;
                end
            endcase
        end
    end

    // Registered outputs; rates change only in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            rate_valid  <= 1'b0;
            normal_rate <= 8'd0;
            arc_rate    <= 8'd0;
            open_rate   <= 8'd0;
            short_rate  <= 8'd0;
        end else begin
            busy       <= (state_s != S_IDLE);
            rate_valid <= (state_r == S_DONE);
            if (state_r == S_DONE) begin
                if (sh_ovf_r) begin
                    normal_rate <= 8'hFF; arc_rate <= 8'hFF; open_rate <= 8'hFF; short_rate <= 8'hFF;
                end else if (sh_total_r == '0) begin
                    normal_rate <= 8'd0; arc_rate <= 8'd0; open_rate <= 8'd0; short_rate <= 8'd0;
                end else begin
                    normal_rate <= q_r[0]; arc_rate <= q_r[1]; open_rate <= q_r[2]; short_rate <= q_r[3];
                end
            end
        end
    end
endmodule
